// File: rtl/attention_pkg.sv
// Shared definitions for the A.V issue sequencer: precision codes, latency map, FSM states.
package attention_pkg;

  typedef enum logic [3:0] {
    PREC_INT4 = 4'd0,
    PREC_INT8 = 4'd1,
    PREC_FP16 = 4'd2
  } prec_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int RET_SLOTS = 4;

  // Unknown codes fall back to the slowest (FP16) pipe.
  function automatic logic [2:0] prec_latency(input logic [3:0] code);
    logic [2:0] k;
    case (prec_e'(code))
      PREC_INT4: k = 3'd1;
      PREC_INT8: k = 3'd2;
      default:   k = 3'd4;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/av_return_tracker.sv
// Tag delay line mirroring the multiplier array latency plus the in-order hazard counter.
// A push lands in slot k-1 and reaches the acc outputs exactly k cycles later.
module av_return_tracker
  import attention_pkg::*;
#(
  parameter int TW = 3,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic [2:0]    query_k_i,
  output logic          can_issue_o,
  input  logic          push_i,
  input  logic [TW-1:0] push_token_i,
  input  logic [BW-1:0] push_batch_i,
  output logic          drained_o,
  output logic          acc_valid_o,
  output logic [TW-1:0] acc_token_o,
  output logic [BW-1:0] acc_batch_o
);

  logic [RET_SLOTS-1:0] vld_q, vld_d;
  logic [TW-1:0]        tok_q [RET_SLOTS];
  logic [TW-1:0]        tok_d [RET_SLOTS];
  logic [BW-1:0]        bat_q [RET_SLOTS];
  logic [BW-1:0]        bat_d [RET_SLOTS];
  logic [2:0]           rem_q, rem_d;
  logic [1:0]           slot;

  assign slot        = 2'(query_k_i - 3'd1);
  // rem tracks the highest occupied slot, so k > rem means slot k-1 is free after the shift.
  assign can_issue_o = query_k_i > rem_q;
  assign drained_o   = (rem_q == 3'd0) && (vld_q[RET_SLOTS-1:1] == '0);
  assign acc_valid_o = vld_q[0];
  assign acc_token_o = tok_q[0];
  assign acc_batch_o = bat_q[0];

  always_comb begin
    vld_d = {1'b0, vld_q[RET_SLOTS-1:1]};
    for (int i = 0; i < RET_SLOTS - 1; i++) begin
      tok_d[i] = tok_q[i+1];
      bat_d[i] = bat_q[i+1];
    end
    tok_d[RET_SLOTS-1] = '0;
    bat_d[RET_SLOTS-1] = '0;
    rem_d = (rem_q == 3'd0) ? 3'd0 : rem_q - 3'd1;
    if (push_i) begin
      vld_d[slot] = 1'b1;
      tok_d[slot] = push_token_i;
      bat_d[slot] = push_batch_i;
      rem_d       = query_k_i - 3'd1;
    end
    if (clear_i) begin
      vld_d = '0;
      rem_d = '0;
      for (int i = 0; i < RET_SLOTS; i++) begin
        tok_d[i] = '0;
        bat_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rem_q <= '0;
      for (int i = 0; i < RET_SLOTS; i++) begin
        tok_q[i] <= '0;
        bat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      rem_q <= rem_d;
      for (int i = 0; i < RET_SLOTS; i++) begin
        tok_q[i] <= tok_d[i];
        bat_q[i] <= bat_d[i];
      end
    end
  end

endmodule

// File: rtl/av_precision_scheduler.sv
// Walks (token, batch) work items into the mixed-precision A.V array, inserting bubbles so results return in order.
// issue_* holds stable while issue_ready is low; the return line keeps shifting regardless.
module av_precision_scheduler
  import attention_pkg::*;
#(
  parameter int  L       = 8,
  parameter int  N       = 1,
  parameter int  E       = 8,
  parameter int  P       = 16,
  localparam int TOTAL   = L * N * E,
  localparam int BATCHES = (TOTAL + P - 1) / P,
  localparam int TW      = (L > 1) ? $clog2(L) : 1,
  localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [L-1:0][3:0] token_precision,
  output logic             busy,
  output logic             done,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TW-1:0]    issue_token,
  output logic [BW-1:0]    issue_batch,
  output logic [3:0]       issue_prec,
  output logic             acc_valid,
  output logic [TW-1:0]    acc_token,
  output logic [BW-1:0]    acc_batch
);

  state_t              state_q, state_d;
  logic [L-1:0][3:0]   prec_q, prec_d;
  logic [TW-1:0]       tok_q, tok_d;
  logic [BW-1:0]       bat_q, bat_d;
  logic [2:0]          k_cur;
  logic                can_issue, drained, fire, last_item, last_batch;

  assign issue_token = tok_q;
  assign issue_batch = bat_q;
  assign issue_prec  = prec_q[tok_q];
  assign k_cur       = prec_latency(issue_prec);
  assign issue_valid = (state_q == ST_ISSUE) && can_issue;
  assign fire        = issue_valid && issue_ready;
  assign last_batch  = bat_q == BW'(BATCHES - 1);
  assign last_item   = last_batch && (tok_q == TW'(L - 1));
  assign busy        = state_q != ST_IDLE;
  assign done        = state_q == ST_DONE;

  av_return_tracker #(.TW(TW), .BW(BW)) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (abort),
    .query_k_i    (k_cur),
    .can_issue_o  (can_issue),
    .push_i       (fire),
    .push_token_i (tok_q),
    .push_batch_i (bat_q),
    .drained_o    (drained),
    .acc_valid_o  (acc_valid),
    .acc_token_o  (acc_token),
    .acc_batch_o  (acc_batch)
  );

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    tok_d   = tok_q;
    bat_d   = bat_q;
    case (state_q)
      ST_IDLE: if (start) begin
        prec_d  = token_precision;
        tok_d   = '0;
        bat_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (fire) begin
        if (last_item) begin
          state_d = ST_DRAIN;
        end else if (last_batch) begin
          bat_d = '0;
          tok_d = tok_q + TW'(1);
        end else begin
          bat_d = bat_q + BW'(1);
        end
      end
      // The final result may still be in slot 0 this cycle; done follows it directly.
      ST_DRAIN: if (drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      tok_d   = '0;
      bat_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prec_q  <= '0;
      tok_q   <= '0;
      bat_q   <= '0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      tok_q   <= tok_d;
      bat_q   <= bat_d;
    end
  end

endmodule

// File: tb/tb_av_precision_scheduler.sv
// Bench for av_precision_scheduler: reference model derives fire/return/done cycles from the latency rules.
module tb_av_precision_scheduler;
  localparam int L = 8, BATCHES = 4, NI = L * BATCHES, TW = 3, BW = 2, HMAX = 512;

  logic clk = 1'b0;
  logic rst_n, start, abort, issue_ready;
  logic [L-1:0][3:0] token_precision;
  logic busy, done, issue_valid, acc_valid;
  logic [TW-1:0] issue_token, acc_token;
  logic [BW-1:0] issue_batch, acc_batch;
  logic [3:0] issue_prec;

  av_precision_scheduler #(.L(8), .N(1), .E(8), .P(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .token_precision(token_precision), .busy(busy), .done(done),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_token(issue_token), .issue_batch(issue_batch), .issue_prec(issue_prec),
    .acc_valid(acc_valid), .acc_token(acc_token), .acc_batch(acc_batch)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int c0;
  logic [3:0] code_t [L];
  bit rdy_pat [HMAX];
  int exp_fire [NI], exp_acc [NI], exp_done;
  int fire_cyc [NI], fire_tok [NI], fire_bat [NI];
  logic [3:0] fire_prec [NI];
  int acc_cyc [NI], acc_tok [NI], acc_bat [NI];
  int n_fire, n_acc, done_cyc, n_done, hold_bad;
  bit vld_hist [HMAX], busy_hist [HMAX], accv_hist [HMAX];

  function automatic int lat_of(input logic [3:0] c);
    return (c == 4'd0) ? 1 : (c == 4'd1) ? 2 : 4;
  endfunction

  // Each item takes the first cycle (after its predecessor) where ready is high and
  // its return lands strictly after the previous return.
  task automatic build_model();
    int t, last_ret, k;
    t = 1;
    last_ret = 0;
    for (int i = 0; i < NI; i++) begin
      k = lat_of(code_t[i / BATCHES]);
      while (!((t + k > last_ret) && rdy_pat[t]) && t < HMAX - 1) t++;
      exp_fire[i] = t;
      exp_acc[i]  = t + k;
      last_ret    = t + k;
      t++;
    end
    exp_done = last_ret + 1;
  endtask

  task automatic run_pass(input int ncyc, input int abort_at, input int rst_at, input bit start_hold);
    bit prev_stall;
    int ptok, pbat, n;
    n = (ncyc < HMAX) ? ncyc : HMAX - 1;
    n_fire = 0; n_acc = 0; n_done = 0; done_cyc = -1; hold_bad = 0; prev_stall = 0;
    ptok = 0; pbat = 0;
    for (int i = 0; i < NI; i++) begin
      fire_cyc[i] = -1; acc_cyc[i] = -1; fire_tok[i] = -1; acc_tok[i] = -1;
      fire_bat[i] = -1; acc_bat[i] = -1; fire_prec[i] = 4'hx;
    end
    for (int t = 0; t < HMAX; t++) begin
      vld_hist[t] = 0; busy_hist[t] = 0; accv_hist[t] = 0;
    end
    @(negedge clk);
    c0 = cyc;
    for (int j = 0; j < L; j++) token_precision[j] = code_t[j];
    start = 1'b1;
    abort = 1'b0;
    issue_ready = rdy_pat[0];
    for (int t = 1; t < n; t++) begin
      @(negedge clk);
      if (t == 1) token_precision = {L{4'($urandom_range(0, 15))}};
      vld_hist[t]  = issue_valid;
      busy_hist[t] = busy;
      accv_hist[t] = acc_valid;
      if (prev_stall && (issue_valid !== 1'b1 || int'(issue_token) != ptok || int'(issue_batch) != pbat))
        hold_bad++;
      prev_stall = (issue_valid === 1'b1) && !rdy_pat[t];
      ptok = int'(issue_token);
      pbat = int'(issue_batch);
      if (issue_valid === 1'b1 && rdy_pat[t]) begin
        if (n_fire < NI) begin
          fire_cyc[n_fire] = t; fire_tok[n_fire] = int'(issue_token);
          fire_bat[n_fire] = int'(issue_batch); fire_prec[n_fire] = issue_prec;
        end
        n_fire++;
      end
      if (acc_valid === 1'b1) begin
        if (n_acc < NI) begin
          acc_cyc[n_acc] = t; acc_tok[n_acc] = int'(acc_token); acc_bat[n_acc] = int'(acc_batch);
        end
        n_acc++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = t;
      end
      start = start_hold && (done_cyc < 0);
      issue_ready = rdy_pat[t];
      abort = (t == abort_at);
      rst_n = (t != rst_at);
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; issue_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, issue_valid, acc_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, issue_valid, acc_valid});
    end
    checks++;
    if ({issue_token, issue_batch, acc_token, acc_batch} !== '0) begin
      errors++; $display("FAIL reset_idx: got %h expected 0", {issue_token, issue_batch, acc_token, acc_batch});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, issue_valid, acc_valid, done} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 0000", {busy, issue_valid, acc_valid, done});
    end
  endtask

  task automatic test_all_int4();
    for (int j = 0; j < L; j++) code_t[j] = 4'd0;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    build_model();
    run_pass(exp_done + 4, -1, -1, 1'b0);
    checks++; if (fire_cyc[0] != 1) begin errors++; $display("FAIL int4_first_fire: got %0d expected 1", fire_cyc[0]); end
    checks++; if (fire_cyc[31] != 32) begin errors++; $display("FAIL int4_last_fire: got %0d expected 32", fire_cyc[31]); end
    checks++; if (acc_cyc[0] != 2 || acc_cyc[31] != 33) begin errors++; $display("FAIL int4_acc_span: got %0d..%0d expected 2..33", acc_cyc[0], acc_cyc[31]); end
    checks++; if (done_cyc != 34 || n_done != 1) begin errors++; $display("FAIL int4_done: got cyc %0d count %0d expected cyc 34 count 1", done_cyc, n_done); end
    checks++; if (!busy_hist[1] || !busy_hist[34] || busy_hist[35]) begin errors++; $display("FAIL int4_busy: got %b%b%b expected 110", busy_hist[1], busy_hist[34], busy_hist[35]); end
    checks++; if (n_fire != NI || n_acc != NI) begin errors++; $display("FAIL int4_counts: got fires %0d accs %0d expected %0d", n_fire, n_acc, NI); end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (fire_tok[i] != i / BATCHES || fire_bat[i] != i % BATCHES || acc_tok[i] != i / BATCHES ||
          acc_bat[i] != i % BATCHES || fire_cyc[i] != exp_fire[i] || acc_cyc[i] != exp_acc[i]) begin
        errors++;
        $display("FAIL int4_item%0d: got fire (%0d,%0d)@%0d acc (%0d,%0d)@%0d expected (%0d,%0d)@%0d/@%0d", i,
                 fire_tok[i], fire_bat[i], fire_cyc[i], acc_tok[i], acc_bat[i], acc_cyc[i],
                 i / BATCHES, i % BATCHES, exp_fire[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_fp16_token0();
    for (int j = 0; j < L; j++) code_t[j] = 4'd0;
    code_t[0] = 4'd2;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    build_model();
    run_pass(exp_done + 4, -1, -1, 1'b0);
    checks++; if (fire_cyc[0] != 1 || fire_cyc[3] != 4) begin errors++; $display("FAIL fp16_tok0_fires: got %0d..%0d expected 1..4", fire_cyc[0], fire_cyc[3]); end
    checks++; if (vld_hist[5] || vld_hist[6] || vld_hist[7]) begin errors++; $display("FAIL fp16_bubbles: got %b%b%b expected 000", vld_hist[5], vld_hist[6], vld_hist[7]); end
    checks++; if (fire_cyc[4] != 8) begin errors++; $display("FAIL fp16_next_fire: got %0d expected 8", fire_cyc[4]); end
    checks++; if (acc_cyc[3] != 8 || acc_cyc[4] != 9) begin errors++; $display("FAIL fp16_acc: got %0d,%0d expected 8,9", acc_cyc[3], acc_cyc[4]); end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (acc_tok[i] != i / BATCHES || acc_bat[i] != i % BATCHES || fire_cyc[i] != exp_fire[i] || acc_cyc[i] != exp_acc[i]) begin
        errors++;
        $display("FAIL fp16_item%0d: got acc (%0d,%0d)@%0d fire@%0d expected @%0d/@%0d", i,
                 acc_tok[i], acc_bat[i], acc_cyc[i], fire_cyc[i], exp_acc[i], exp_fire[i]);
      end
    end
  endtask

  task automatic test_mixed_transitions();
    for (int j = 0; j < L; j++) code_t[j] = 4'($urandom_range(0, 15));
    code_t[0] = 4'd1; code_t[1] = 4'd0; code_t[2] = 4'd2;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    build_model();
    run_pass(exp_done + 4, -1, -1, 1'b0);
    checks++; if (fire_cyc[4] - fire_cyc[3] != 2) begin errors++; $display("FAIL int8_to_int4_gap: got %0d expected 2", fire_cyc[4] - fire_cyc[3]); end
    checks++; if (fire_cyc[8] - fire_cyc[7] != 1) begin errors++; $display("FAIL int4_to_fp16_gap: got %0d expected 1", fire_cyc[8] - fire_cyc[7]); end
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL mixed_done: got %0d expected %0d", done_cyc, exp_done); end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (acc_tok[i] != fire_tok[i] || acc_bat[i] != fire_bat[i] ||
          acc_cyc[i] - fire_cyc[i] != lat_of(code_t[i / BATCHES]) || fire_cyc[i] != exp_fire[i]) begin
        errors++;
        $display("FAIL mixed_item%0d: got fire (%0d,%0d)@%0d acc (%0d,%0d)@%0d expected delay %0d fire@%0d", i,
                 fire_tok[i], fire_bat[i], fire_cyc[i], acc_tok[i], acc_bat[i], acc_cyc[i],
                 lat_of(code_t[i / BATCHES]), exp_fire[i]);
      end
    end
  endtask

  task automatic test_stall();
    for (int j = 0; j < L; j++) code_t[j] = 4'd0;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = !(t >= 10 && t <= 14);
    build_model();
    run_pass(exp_done + 4, -1, -1, 1'b0);
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", hold_bad); end
    checks++; if (fire_cyc[9] != 15 || fire_cyc[8] != 9) begin errors++; $display("FAIL stall_fires: got %0d,%0d expected 9,15", fire_cyc[8], fire_cyc[9]); end
    checks++; if (acc_cyc[8] != 10) begin errors++; $display("FAIL stall_inflight_acc: got %0d expected 10", acc_cyc[8]); end
    checks++; if (n_fire != NI || n_acc != NI) begin errors++; $display("FAIL stall_counts: got %0d/%0d expected %0d", n_fire, n_acc, NI); end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (fire_tok[i] != i / BATCHES || fire_bat[i] != i % BATCHES || acc_cyc[i] != exp_acc[i] || acc_tok[i] != i / BATCHES) begin
        errors++;
        $display("FAIL stall_item%0d: got fire (%0d,%0d) acc tok %0d @%0d expected acc @%0d", i,
                 fire_tok[i], fire_bat[i], acc_tok[i], acc_cyc[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_code7();
    for (int j = 0; j < L; j++) code_t[j] = 4'd0;
    code_t[3] = 4'd7;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    build_model();
    run_pass(exp_done + 4, -1, -1, 1'b0);
    checks++; if (fire_prec[12] !== 4'd7) begin errors++; $display("FAIL code7_prec: got %0d expected 7", fire_prec[12]); end
    checks++; if (acc_cyc[12] - fire_cyc[12] != 4) begin errors++; $display("FAIL code7_latency: got %0d expected 4", acc_cyc[12] - fire_cyc[12]); end
    checks++; if (fire_cyc[16] - fire_cyc[15] != 4) begin errors++; $display("FAIL code7_gap: got %0d expected 4", fire_cyc[16] - fire_cyc[15]); end
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL code7_done: got %0d expected %0d", done_cyc, exp_done); end
  endtask

  task automatic test_random(input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int j = 0; j < L; j++) code_t[j] = 4'($urandom_range(0, 15));
      for (int t = 0; t < HMAX; t++) rdy_pat[t] = (t > 200) || ($urandom_range(0, 3) != 0);
      build_model();
      run_pass(exp_done + 4, -1, -1, 1'b1);
      checks++;
      if (done_cyc != exp_done || n_done != 1 || hold_bad != 0 || n_fire != NI || n_acc != NI) begin
        errors++;
        $display("FAIL random%0d_pass: got done@%0d x%0d holdbad %0d fires %0d accs %0d expected done@%0d x1 0 %0d %0d",
                 p, done_cyc, n_done, hold_bad, n_fire, n_acc, exp_done, NI, NI);
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (fire_cyc[i] != exp_fire[i] || acc_cyc[i] != exp_acc[i] || acc_tok[i] != i / BATCHES ||
            acc_bat[i] != i % BATCHES || fire_prec[i] !== code_t[i / BATCHES]) begin
          errors++;
          $display("FAIL random%0d_item%0d: got fire@%0d acc (%0d,%0d)@%0d prec %0d expected fire@%0d acc@%0d prec %0d",
                   p, i, fire_cyc[i], acc_tok[i], acc_bat[i], acc_cyc[i], fire_prec[i],
                   exp_fire[i], exp_acc[i], code_t[i / BATCHES]);
        end
      end
    end
  endtask

  task automatic test_abort();
    for (int j = 0; j < L; j++) code_t[j] = 4'($urandom_range(0, 15));
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    run_pass(20, 10, -1, 1'b0);
    checks++; if (!busy_hist[10]) begin errors++; $display("FAIL abort_pre_busy: got 0 expected 1"); end
    checks++; if (busy_hist[11] || accv_hist[11] || vld_hist[11]) begin errors++; $display("FAIL abort_next: got busy %b acc %b vld %b expected 000", busy_hist[11], accv_hist[11], vld_hist[11]); end
    checks++; if (n_done != 0 || busy_hist[19]) begin errors++; $display("FAIL abort_no_done: got dones %0d busy %b expected 0 0", n_done, busy_hist[19]); end
  endtask

  task automatic test_reset_drain();
    for (int j = 0; j < L; j++) code_t[j] = 4'd2;
    for (int t = 0; t < HMAX; t++) rdy_pat[t] = 1'b1;
    run_pass(42, -1, 34, 1'b0);
    checks++; if (!busy_hist[33] || !accv_hist[33] || n_fire != NI) begin errors++; $display("FAIL rstdrain_pre: got busy %b acc %b fires %0d expected 1 1 %0d", busy_hist[33], accv_hist[33], n_fire, NI); end
    checks++; if (busy_hist[35] || accv_hist[35]) begin errors++; $display("FAIL rstdrain_next: got busy %b acc %b expected 00", busy_hist[35], accv_hist[35]); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL rstdrain_no_done: got %0d expected 0", n_done); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; issue_ready = 1'b1; token_precision = '0;
    test_reset();
    test_all_int4();
    test_fp16_token0();
    test_mixed_transitions();
    test_stall();
    test_code7();
    test_random(3);
    test_abort();
    test_random(1);
    test_reset_drain();
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
